// File: rtl/user_io_pkg.sv
// Shared constants and types for the user-IO SPI responder.
package user_io_pkg;

    localparam logic [7:0] CMD_BUTTONS  = 8'h01;
    localparam logic [7:0] CMD_JOY0     = 8'h02;
    localparam logic [7:0] CMD_JOY1     = 8'h03;
    localparam logic [7:0] CMD_PS2KBD   = 8'h05;
    localparam logic [7:0] CMD_CONF_STR = 8'h14;
    localparam logic [7:0] CMD_STATUS   = 8'h1E;

    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/user_io_fifo.sv
// Four-entry synchronous byte FIFO for the keyboard stream; head is a registered entry.
module user_io_fifo
    import user_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    logic [7:0] mem_q [FIFO_DEPTH];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       pop_ok, push_ok;

    always_comb begin
        empty   = (count_q == 3'd0);
        full    = (count_q == 3'(FIFO_DEPTH));
        pop_ok  = pop && !empty;
        // A pop frees the slot a same-cycle push needs when full.
        push_ok = push && (!full || pop_ok);
        head    = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/user_io_responder.sv
// Guest-side SPI responder for the user-IO channel: decodes command/data bytes into
// core registers, a keyboard byte stream and a status word, and returns core type/config.
module user_io_responder
    import user_io_pkg::*;
#(
    parameter logic [7:0]  CORE_TYPE = 8'hA4,
    parameter int unsigned CONF_LEN  = 64,
    localparam int unsigned CONF_AW  = (CONF_LEN > 1) ? $clog2(CONF_LEN) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               spi_sck,
    input  logic               spi_ss_n,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic [7:0]         buttons,
    output logic [7:0]         joy0,
    output logic [7:0]         joy1,
    output logic [31:0]        status,
    output logic               status_strobe,
    output logic [7:0]         ps2_data,
    output logic               ps2_valid,
    input  logic               ps2_ready,
    output logic               ps2_overflow,
    output logic [CONF_AW-1:0] conf_addr,
    input  logic [7:0]         conf_data
);

    logic [1:0]  sck_sync_q, ss_sync_q, mosi_sync_q;
    logic        sck_prev_q, rise_q, fall_q, ss_q, mosi_q, armed_q;
    state_e      state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  byte_idx_q, cmd_q, shift_q, tx_q, conf_idx_q;
    logic [23:0] shadow_q;
    logic        reload_q;

    logic        rise, fall, byte_done, fifo_push, fifo_full, fifo_empty, ps2_drop;
    logic [7:0]  rx_byte, next_tx;

    assign conf_addr = conf_idx_q[CONF_AW-1:0];

    always_comb begin
        rise      = rise_q && !ss_q;
        fall      = fall_q && !ss_q;
        rx_byte   = {shift_q[6:0], mosi_q};
        byte_done = rise && (bit_cnt_q == 3'd7) && (state_q != IDLE);
        next_tx   = ((cmd_q == CMD_CONF_STR) && (32'(conf_idx_q) < CONF_LEN)) ? conf_data : 8'h00;
        fifo_push = byte_done && (state_q == DATA) && (cmd_q == CMD_PS2KBD);
        // Full implies non-empty, so a ready consumer always makes room.
        ps2_drop  = fifo_push && fifo_full && !ps2_ready;
        ps2_valid = !fifo_empty;
    end

    // ss_n pipeline resets low so a select held low across reset is never seen as a new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q  <= 2'b00;
            ss_sync_q   <= 2'b00;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            ss_q        <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], spi_sck};
            ss_sync_q   <= {ss_sync_q[0], spi_ss_n};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sck_prev_q  <= sck_sync_q[1];
            rise_q      <= sck_sync_q[1] && !sck_prev_q;
            fall_q      <= !sck_sync_q[1] && sck_prev_q;
            ss_q        <= ss_sync_q[1];
            mosi_q      <= mosi_sync_q[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            armed_q       <= 1'b0;
            bit_cnt_q     <= 3'd0;
            byte_idx_q    <= 8'd0;
            cmd_q         <= 8'h00;
            shift_q       <= 8'h00;
            tx_q          <= 8'h00;
            conf_idx_q    <= 8'd0;
            shadow_q      <= 24'h0;
            reload_q      <= 1'b0;
            spi_miso      <= 1'b0;
            buttons       <= 8'h00;
            joy0          <= 8'h00;
            joy1          <= 8'h00;
            status        <= 32'h0;
            status_strobe <= 1'b0;
            ps2_overflow  <= 1'b0;
        end else begin
            status_strobe <= 1'b0;
            if (ss_q) armed_q <= 1'b1;
            if (ps2_drop) ps2_overflow <= 1'b1;

            if (state_q == IDLE || ss_q) begin
                bit_cnt_q  <= 3'd0;
                byte_idx_q <= 8'd0;
                reload_q   <= 1'b0;
                spi_miso   <= 1'b0;
                state_q    <= IDLE;
                if (state_q == IDLE && armed_q && !ss_q) begin
                    state_q  <= CMD;
                    tx_q     <= CORE_TYPE;
                    spi_miso <= CORE_TYPE[7];
                end
            end else begin
                if (rise) begin
                    shift_q   <= rx_byte;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                // Reload waits for the fall so conf_data has settled on the new address.
                if (fall) begin
                    if (reload_q) begin
                        tx_q       <= next_tx;
                        spi_miso   <= next_tx[7];
                        reload_q   <= 1'b0;
                        conf_idx_q <= sat_inc8(conf_idx_q);
                    end else begin
                        spi_miso <= tx_q[3'd7 - bit_cnt_q];
                    end
                end
                if (byte_done) begin
                    reload_q <= 1'b1;
                    if (state_q == CMD) begin
                        cmd_q      <= rx_byte;
                        state_q    <= DATA;
                        byte_idx_q <= 8'd0;
                        conf_idx_q <= 8'd0;
                    end else begin
                        byte_idx_q <= sat_inc8(byte_idx_q);
                        case (cmd_q)
                            CMD_BUTTONS: if (byte_idx_q == 8'd0) buttons <= rx_byte;
                            CMD_JOY0:    if (byte_idx_q == 8'd0) joy0 <= rx_byte;
                            CMD_JOY1:    if (byte_idx_q == 8'd0) joy1 <= rx_byte;
                            CMD_STATUS: begin
                                case (byte_idx_q)
                                    8'd0: shadow_q[7:0]   <= rx_byte;
                                    8'd1: shadow_q[15:8]  <= rx_byte;
                                    8'd2: shadow_q[23:16] <= rx_byte;
                                    8'd3: begin
                                        status        <= {rx_byte, shadow_q};
                                        status_strobe <= 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    user_io_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (rx_byte),
        .pop       (ps2_ready),
        .head      (ps2_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_user_io_responder.sv
// Directed bench for user_io_responder acting as the SPI master; expectations go through a
// scoreboard queue and are checked with immediate assertions.
module tb_user_io_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_ss_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] buttons, joy0, joy1, ps2_data, conf_data;
    logic [31:0] status;
    logic       status_strobe, ps2_valid, ps2_overflow;
    logic       ps2_ready = 1'b0;
    logic [0:0] conf_addr;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   strobe_cnt = 0;
    logic [7:0] rx;

    always #5 clk = ~clk;

    // Registered config ROM: "AB".
    always_ff @(posedge clk) conf_data <= (conf_addr == 1'b0) ? 8'h41 : 8'h42;

    always @(posedge clk) if (status_strobe) strobe_cnt++;

    user_io_responder #(
        .CORE_TYPE (8'hA4),
        .CONF_LEN  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_sck       (spi_sck),
        .spi_ss_n      (spi_ss_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .buttons       (buttons),
        .joy0          (joy0),
        .joy1          (joy1),
        .status        (status),
        .status_strobe (status_strobe),
        .ps2_data      (ps2_data),
        .ps2_valid     (ps2_valid),
        .ps2_ready     (ps2_ready),
        .ps2_overflow  (ps2_overflow),
        .conf_addr     (conf_addr),
        .conf_data     (conf_data)
    );

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val)
            else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Mode 0, MSB first; MISO is sampled just before each rising edge.
    task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = d[i];
            #60;
            r[i] = spi_miso;
            spi_sck = 1'b1;
            #60;
            spi_sck = 1'b0;
        end
    endtask

    task automatic ss_low();
        spi_ss_n = 1'b0;
        #100;
    endtask

    task automatic ss_high();
        #100;
        spi_ss_n = 1'b1;
        #100;
    endtask

    task automatic pop_one();
        ps2_ready = 1'b1;
        @(posedge clk);
        #1;
        ps2_ready = 1'b0;
        #9;
    endtask

    initial begin
        #30;
        reset = 1'b0;
        #50;

        // Reset state
        expect_val("reset_joy0", 32'h0);     check({24'h0, joy0});
        expect_val("reset_status", 32'h0);   check(status);
        expect_val("reset_ps2_valid", 32'h0); check({31'h0, ps2_valid});
        expect_val("reset_miso", 32'h0);     check({31'h0, spi_miso});

        // Joystick 0, then joystick 1
        ss_low();
        expect_val("joy0_cmd_miso", 32'hA4); spi_bits(8'h02, 8, rx); check({24'h0, rx});
        expect_val("joy0_data_miso", 32'h00); spi_bits(8'h5A, 8, rx); check({24'h0, rx});
        ss_high();
        expect_val("joy0_value", 32'h5A); check({24'h0, joy0});
        ss_low();
        expect_val("joy1_cmd_miso", 32'hA4); spi_bits(8'h03, 8, rx); check({24'h0, rx});
        spi_bits(8'h81, 8, rx);
        ss_high();
        expect_val("joy1_value", 32'h81); check({24'h0, joy1});
        expect_val("joy0_kept", 32'h5A);  check({24'h0, joy0});

        // Status word, then a truncated status transaction
        ss_low();
        spi_bits(8'h1E, 8, rx);
        spi_bits(8'h78, 8, rx);
        spi_bits(8'h56, 8, rx);
        spi_bits(8'h34, 8, rx);
        spi_bits(8'h12, 8, rx);
        ss_high();
        expect_val("status_value", 32'h12345678); check(status);
        expect_val("status_strobes", 32'd1);      check(32'(strobe_cnt));
        ss_low();
        spi_bits(8'h1E, 8, rx);
        spi_bits(8'hAA, 8, rx);
        spi_bits(8'hBB, 8, rx);
        ss_high();
        expect_val("status_short_kept", 32'h12345678); check(status);
        expect_val("status_short_no_strobe", 32'd1);   check(32'(strobe_cnt));

        // Keyboard FIFO overflow and drain
        ss_low();
        spi_bits(8'h05, 8, rx);
        spi_bits(8'h1C, 8, rx);
        spi_bits(8'hF0, 8, rx);
        spi_bits(8'h1C, 8, rx);
        spi_bits(8'h29, 8, rx);
        spi_bits(8'h5A, 8, rx);
        ss_high();
        expect_val("ps2_valid_full", 32'h1);  check({31'h0, ps2_valid});
        expect_val("ps2_overflow", 32'h1);    check({31'h0, ps2_overflow});
        expect_val("ps2_pop0", 32'h1C); check({24'h0, ps2_data}); pop_one();
        expect_val("ps2_pop1", 32'hF0); check({24'h0, ps2_data}); pop_one();
        expect_val("ps2_pop2", 32'h1C); check({24'h0, ps2_data}); pop_one();
        expect_val("ps2_pop3", 32'h29); check({24'h0, ps2_data}); pop_one();
        expect_val("ps2_drained", 32'h0);     check({31'h0, ps2_valid});
        expect_val("ps2_overflow_sticky", 32'h1); check({31'h0, ps2_overflow});

        // Config string read
        ss_low();
        expect_val("conf_cmd_miso", 32'hA4); spi_bits(8'h14, 8, rx); check({24'h0, rx});
        expect_val("conf_byte0", 32'h41);    spi_bits(8'h00, 8, rx); check({24'h0, rx});
        expect_val("conf_byte1", 32'h42);    spi_bits(8'h00, 8, rx); check({24'h0, rx});
        expect_val("conf_past_end", 32'h00); spi_bits(8'h00, 8, rx); check({24'h0, rx});
        ss_high();

        // Partial command byte is discarded
        ss_low();
        spi_bits(8'h01, 5, rx);
        ss_high();
        ss_low();
        spi_bits(8'h01, 8, rx);
        spi_bits(8'h0F, 8, rx);
        ss_high();
        expect_val("buttons_after_partial", 32'h0F); check({24'h0, buttons});

        // Reset in the middle of a status transaction
        ss_low();
        spi_bits(8'h1E, 8, rx);
        spi_bits(8'h11, 8, rx);
        spi_bits(8'hFF, 3, rx);
        reset = 1'b1;
        #1;
        expect_val("rst_status", 32'h0);   check(status);
        expect_val("rst_buttons", 32'h0);  check({24'h0, buttons});
        expect_val("rst_joy", 32'h0);      check({16'h0, joy0, joy1});
        expect_val("rst_ps2_ovf", 32'h0);  check({31'h0, ps2_overflow});
        expect_val("rst_miso", 32'h0);     check({31'h0, spi_miso});
        #29;
        reset = 1'b0;
        #20;
        spi_bits(8'hFF, 5, rx);
        ss_high();
        expect_val("post_rst_idle_status", 32'h0); check(status);
        strobe_cnt = 0;
        ss_low();
        expect_val("post_rst_cmd_miso", 32'hA4); spi_bits(8'h1E, 8, rx); check({24'h0, rx});
        spi_bits(8'hEF, 8, rx);
        spi_bits(8'hBE, 8, rx);
        spi_bits(8'hAD, 8, rx);
        spi_bits(8'hDE, 8, rx);
        ss_high();
        expect_val("post_rst_status", 32'hDEADBEEF); check(status);
        expect_val("post_rst_strobe", 32'd1);        check(32'(strobe_cnt));

        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d entries, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
